// File: rtl/lc4_wb_queue_ss.sv
// rtl/lc4_wb_queue_ss.sv - two-pipe writeback queue for the superscalar LC4 register file
//
// Buffers results from pipe A and pipe B in program order (A older than B
// within a cycle) and drains up to two per cycle onto the register file's
// A/B write ports. Exports a per-register pending-write mask for decode.
//
// Optional feature macro: LC4_WB_MERGE_EN
//   defined   - A and B valid to the same rd collapse into one entry {rd_B, data_B}
//   undefined - both results are always enqueued as separate entries
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   gwe                 global write enable; state advances only when high
//   i_valid_A/i_rd_A/i_data_A   pipe A result (older)
//   i_valid_B/i_rd_B/i_data_B   pipe B result (younger)
//   o_ready             at least two free entries
//   i_drain_en          register file accepts writes this cycle
//   o_rd_A/o_wdata_A/o_rd_we_A  oldest entry onto write port A
//   o_rd_B/o_wdata_B/o_rd_we_B  second-oldest entry onto write port B
//   o_count/o_empty/o_full      occupancy
//   o_busy              bit r set iff an occupied entry targets register r
//   o_overflow          sticky: a valid result was dropped

module lc4_wb_queue_ss #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gwe,
  input  logic                     i_valid_A,
  input  logic [2:0]               i_rd_A,
  input  logic [n-1:0]             i_data_A,
  input  logic                     i_valid_B,
  input  logic [2:0]               i_rd_B,
  input  logic [n-1:0]             i_data_B,
  output logic                     o_ready,
  input  logic                     i_drain_en,
  output logic [2:0]               o_rd_A,
  output logic [n-1:0]             o_wdata_A,
  output logic                     o_rd_we_A,
  output logic [2:0]               o_rd_B,
  output logic [n-1:0]             o_wdata_B,
  output logic                     o_rd_we_B,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [7:0]               o_busy,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]    rd_q   [DEPTH];
  logic [n-1:0]  data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          overflow;

  logic [PW-1:0] head_p1, tail_p1;
  logic          merge, any_valid, accept;
  logic [1:0]    n_enq, n_enq_eff, n_deq;
  logic [2:0]    w0_rd;
  logic [n-1:0]  w0_data;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Space is judged on the current count only; a dequeue in the same
  // cycle does not free room for this cycle's enqueue.
  assign o_ready   = (count <= CW'(DEPTH - 2));
  assign o_count   = count;
  assign o_empty   = (count == '0);
  assign o_full    = (count == CW'(DEPTH));
  assign o_overflow = overflow;

  assign o_rd_we_A = i_drain_en & (count >= CW'(1));
  assign o_rd_we_B = i_drain_en & (count >= CW'(2));
  assign o_rd_A    = rd_q[head];
  assign o_wdata_A = data_q[head];
  assign o_rd_B    = rd_q[head_p1];
  assign o_wdata_B = data_q[head_p1];

`ifdef LC4_WB_MERGE_EN
  // Same destination in one cycle: only the younger (B) value matters.
  assign merge = i_valid_A & i_valid_B & (i_rd_A == i_rd_B);
`else
  assign merge = 1'b0;
`endif

  assign any_valid = i_valid_A | i_valid_B;
  assign accept    = gwe & o_ready & any_valid;
  assign n_enq     = merge ? 2'd1 : ({1'b0, i_valid_A} + {1'b0, i_valid_B});
  assign n_enq_eff = accept ? n_enq : 2'd0;
  assign n_deq     = {1'b0, o_rd_we_A} + {1'b0, o_rd_we_B};

  // Slot at tail holds A unless A is absent or merged away; slot tail+1
  // is only used when two separate entries go in.
  assign w0_rd   = (i_valid_A & ~merge) ? i_rd_A   : i_rd_B;
  assign w0_data = (i_valid_A & ~merge) ? i_data_A : i_data_B;

  // Entries being drained this cycle are still reported busy.
  always_comb begin
    o_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) o_busy[rd_q[head + PW'(i)]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (gwe) begin
      if (accept) begin
        rd_q[tail]   <= w0_rd;
        data_q[tail] <= w0_data;
        if (n_enq == 2'd2) begin
          rd_q[tail_p1]   <= i_rd_B;
          data_q[tail_p1] <= i_data_B;
        end
      end
      tail  <= tail + PW'(n_enq_eff);
      head  <= head + PW'(n_deq);
      count <= count + CW'(n_enq_eff) - CW'(n_deq);
      if (any_valid & ~o_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc4_wb_queue_ss.sv
// tb/tb_lc4_wb_queue_ss.sv - scoreboard bench for lc4_wb_queue_ss
module tb_lc4_wb_queue_ss;
  localparam int N = 16;
  localparam int DEPTH = 4;
`ifdef LC4_WB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]   rd;
    logic [N-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gwe = 1'b0;
  logic i_valid_A = 1'b0, i_valid_B = 1'b0, i_drain_en = 1'b0;
  logic [2:0] i_rd_A = '0, i_rd_B = '0;
  logic [N-1:0] i_data_A = '0, i_data_B = '0;
  logic o_ready, o_rd_we_A, o_rd_we_B, o_empty, o_full, o_overflow;
  logic [2:0] o_rd_A, o_rd_B;
  logic [N-1:0] o_wdata_A, o_wdata_B;
  logic [2:0] o_count;
  logic [7:0] o_busy;

  ent_t sbq[$];
  logic [N-1:0] rf [8];
  logic m_ovf = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic ewa, ewb;

  lc4_wb_queue_ss #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .gwe(gwe),
    .i_valid_A(i_valid_A), .i_rd_A(i_rd_A), .i_data_A(i_data_A),
    .i_valid_B(i_valid_B), .i_rd_B(i_rd_B), .i_data_B(i_data_B),
    .o_ready(o_ready), .i_drain_en(i_drain_en),
    .o_rd_A(o_rd_A), .o_wdata_A(o_wdata_A), .o_rd_we_A(o_rd_we_A),
    .o_rd_B(o_rd_B), .o_wdata_B(o_wdata_B), .o_rd_we_B(o_rd_we_B),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Register file model: port B written last so it wins on equal rd.
  always @(posedge clk) begin
    if (rst_n && gwe) begin
      if (o_rd_we_A) rf[o_rd_A] <= o_wdata_A;
      if (o_rd_we_B) rf[o_rd_B] <= o_wdata_B;
    end
  end

  // Scoreboard consumer: write ports checked against the oldest expected entries.
  always @(negedge clk) begin
    if (rst_n) begin
      ewa = i_drain_en && (sbq.size() >= 1);
      ewb = i_drain_en && (sbq.size() >= 2);
      n_cmp++;
      if (o_rd_we_A !== ewa) begin
        n_bad++;
        $display("FAIL we_A: got %b expected %b at %0t", o_rd_we_A, ewa, $time);
      end
      n_cmp++;
      if (o_rd_we_B !== ewb) begin
        n_bad++;
        $display("FAIL we_B: got %b expected %b at %0t", o_rd_we_B, ewb, $time);
      end
      if (ewa) begin
        n_cmp++;
        if ({o_rd_A, o_wdata_A} !== sbq[0]) begin
          n_bad++;
          $display("FAIL port_A: got r%0d/%h expected r%0d/%h at %0t",
                   o_rd_A, o_wdata_A, sbq[0].rd, sbq[0].data, $time);
        end
      end
      if (ewb) begin
        n_cmp++;
        if ({o_rd_B, o_wdata_B} !== sbq[1]) begin
          n_bad++;
          $display("FAIL port_B: got r%0d/%h expected r%0d/%h at %0t",
                   o_rd_B, o_wdata_B, sbq[1].rd, sbq[1].data, $time);
        end
      end
      if (gwe && ewa) void'(sbq.pop_front());
      if (gwe && ewb) void'(sbq.pop_front());
    end
  end

  // One clock: drive inputs, take the edge, push what the queue should accept.
  task automatic cycle(input logic g, input logic va, input logic [2:0] ra, input logic [N-1:0] da,
                       input logic vb, input logic [2:0] rb, input logic [N-1:0] db, input logic dr);
    int pre;
    gwe = g; i_valid_A = va; i_rd_A = ra; i_data_A = da;
    i_valid_B = vb; i_rd_B = rb; i_data_B = db; i_drain_en = dr;
    pre = sbq.size();
    @(posedge clk);
    if (g) begin
      if (DEPTH - pre >= 2) begin
        if (MERGE && va && vb && ra == rb) sbq.push_back({rb, db});
        else begin
          if (va) sbq.push_back({ra, da});
          if (vb) sbq.push_back({rb, db});
        end
      end else if (va || vb) m_ovf = 1'b1;
    end
    #1;
  endtask

  function automatic logic [7:0] exp_busy();
    logic [7:0] b = '0;
    foreach (sbq[i]) b[sbq[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_empty !== 1'b1 || o_full !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_flags: got empty=%b full=%b ready=%b expected 1 0 1", o_empty, o_full, o_ready); end
    n_cmp++; if ({o_rd_A, o_wdata_A, o_rd_B, o_wdata_B} !== '0) begin
      n_bad++; $display("FAIL rst_ports: got %h expected 0", {o_rd_A, o_wdata_A, o_rd_B, o_wdata_B}); end
    n_cmp++; if (o_busy !== 8'h00 || o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy_ovf: got %h/%b expected 00/0", o_busy, o_overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 1, 3'd1, 16'h0101, 1, 3'd4, 16'h0404, 0);
    cycle(1, 1, 3'd7, 16'h0707, 0, 3'd0, 16'h0, 0);
    n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL pre_rst_count: got %0d expected 3", o_count); end
    i_drain_en = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_count !== 3'd0 || o_empty !== 1'b1) begin
      n_bad++; $display("FAIL midrst_count: got %0d/%b expected 0/1", o_count, o_empty); end
    n_cmp++; if (o_busy !== 8'h00 || o_rd_we_A !== 1'b0) begin
      n_bad++; $display("FAIL midrst_busy_we: got %h/%b expected 00/0", o_busy, o_rd_we_A); end
    sbq.delete();
    m_ovf = 1'b0;
    rst_n = 1'b1;
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL postrst_count: got %0d expected 0", o_count); end
  endtask

  task automatic test_dual();
    cycle(1, 1, 3'd2, 16'h1111, 1, 3'd5, 16'h2222, 0);
    n_cmp++; if (o_count !== 3'd2) begin n_bad++; $display("FAIL dual_count: got %0d expected 2", o_count); end
    n_cmp++; if (o_busy !== 8'h24) begin n_bad++; $display("FAIL dual_busy: got %h expected 24", o_busy); end
    n_cmp++; if (o_busy !== exp_busy()) begin n_bad++; $display("FAIL dual_busy_model: got %h expected %h", o_busy, exp_busy()); end
    i_valid_A = 1'b0; i_valid_B = 1'b0; i_drain_en = 1'b1;
    #1;
    n_cmp++; if ({o_rd_A, o_wdata_A, o_rd_B, o_wdata_B} !== {3'd2, 16'h1111, 3'd5, 16'h2222}) begin
      n_bad++; $display("FAIL dual_ports: got %h expected %h",
                        {o_rd_A, o_wdata_A, o_rd_B, o_wdata_B}, {3'd2, 16'h1111, 3'd5, 16'h2222}); end
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL dual_drained: got %0d expected 0", o_count); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 6; i++) cycle(1, 1, 3'(i), 16'(i), 0, 3'd0, 16'h0, 1);
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0 || o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL wrap_end: got count=%0d ovf=%b expected 0 0", o_count, o_overflow); end
    n_cmp++; if (rf[6] !== 16'd6) begin n_bad++; $display("FAIL wrap_rf6: got %h expected 0006", rf[6]); end
  endtask

  task automatic test_overflow();
    cycle(1, 1, 3'd1, 16'h00a1, 1, 3'd2, 16'h00b2, 0);
    cycle(1, 0, 3'd0, 16'h0, 1, 3'd3, 16'h00c3, 0);
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b expected 0", o_ready); end
    cycle(1, 1, 3'd4, 16'hdead, 1, 3'd5, 16'hbeef, 0);
    n_cmp++; if (o_count !== 3'd3 || o_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_drop: got count=%0d ovf=%b expected 3 1", o_count, o_overflow); end
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0 || o_overflow !== m_ovf || o_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky: got count=%0d ovf=%b expected 0 1", o_count, o_overflow); end
  endtask

  task automatic test_gwe();
    cycle(1, 1, 3'd1, 16'h1234, 1, 3'd6, 16'h5678, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 3'd0, 16'hffff, 1, 3'd7, 16'heeee, 1);
      n_cmp++; if (o_count !== 3'd2 || o_busy !== 8'h42) begin
        n_bad++; $display("FAIL gwe_hold: got count=%0d busy=%h expected 2 42", o_count, o_busy); end
      n_cmp++; if (o_rd_we_A !== 1'b1 || o_rd_we_B !== 1'b1) begin
        n_bad++; $display("FAIL gwe_track: got we=%b%b expected 11", o_rd_we_A, o_rd_we_B); end
    end
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL gwe_drain: got %0d expected 0", o_count); end
  endtask

  task automatic test_same_rd();
    cycle(1, 1, 3'd3, 16'haaaa, 1, 3'd3, 16'hbbbb, 0);
    n_cmp++; if (o_count !== (MERGE ? 3'd1 : 3'd2)) begin
      n_bad++; $display("FAIL same_count: got %0d expected %0d", o_count, MERGE ? 1 : 2); end
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0 || rf[3] !== 16'hbbbb) begin
      n_bad++; $display("FAIL same_rf: got count=%0d r3=%h expected 0 bbbb", o_count, rf[3]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 3'($urandom_range(0, 7)), 16'($urandom), 1, 3'($urandom_range(0, 7)), 16'($urandom), 1);
      n_cmp++; if (o_count !== 3'd2 || o_count !== 3'(sbq.size())) begin
        n_bad++; $display("FAIL b2b_count: got %0d expected 2", o_count); end
      n_cmp++; if (o_busy !== exp_busy()) begin
        n_bad++; $display("FAIL b2b_busy: got %h expected %h", o_busy, exp_busy()); end
    end
    cycle(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1);
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL b2b_drain: got %0d expected 0", o_count); end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) rf[r] = '0;
    test_reset();
    test_dual();
    test_wrap();
    test_overflow();
    test_gwe();
    test_same_rd();
    test_back_to_back();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
